serial_adder_sequencer: RTL
===========================

Name: serial_adder_sequencer

Overview:
- Sequences the 1-bit full adder with carry latch through a multi-bit addition, LSB first.
- Captures two WIDTH-bit operands on start, presents one bit pair per step to the serial adder, and latches each sum bit and the running carry.
- Honours the runstop pause control and drives the 5-LED status display.
- Sits between operand sources (switches/registers) and the adder/LED output stage.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..16)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  level-sampled request to begin an addition; honoured only in IDLE
runstop  input  1  1 = stop (hold state), 0 = run
op_a  input  WIDTH  operand A, captured on accepted start
op_b  input  WIDTH  operand B, captured on accepted start
bit_a  output  1  current A bit presented to adder (shift reg LSB)
bit_b  output  1  current B bit presented to adder (shift reg LSB)
carry_q  output  1  carry latch contents
sum  output  WIDTH  result register; held until next accepted start
cout  output  1  final carry of last completed addition
busy  output  1  high in RUN and PAUSE
done  output  1  one-cycle pulse in DONE state
led  output  5  led[0] last sum bit, led[1] carry_q, led[2] busy, led[3] paused, led[4] cout

Behaviour:
- Reset (async, any state): state=IDLE. Shift regs, sum, carry_q, cout, bit counter, done, busy and led all go to 0.
- States: IDLE, RUN, PAUSE, DONE. Registered state; outputs busy/done/led decoded from registered state and registers.
- IDLE:
  - start=1 at an edge -> load shift_a<=op_a, shift_b<=op_b, carry_q<=0, sum<=0, cnt<=0, cout<=0; go to RUN.
  - runstop is ignored in IDLE.
- RUN, runstop=0 at an edge (one bit step):
  - s = a0^b0^carry_q; carry_q <= majority(a0,b0,carry_q).
  - sum <= {s, sum[WIDTH-1:1]}; shift_a, shift_b shift right with 0 fill; cnt++.
  - led[0] <= s.
  - If cnt==WIDTH-1 before the increment -> DONE, and cout <= new carry.
- RUN, runstop=1 at an edge -> PAUSE; no step, all datapath registers hold.
- PAUSE:
  - runstop=1 -> stay.
  - runstop=0 -> RUN; no step on this transition edge.
  - led[3]=1 only in PAUSE.
- DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally. start in DONE is ignored.
- Latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH. Each stop episode adds P+1 cycles, where P = edges sampled with runstop=1.
- Ignored inputs:
  - start while busy or in DONE: no effect.
  - op_a/op_b changes after capture: no effect.
- Arithmetic:
  - {cout,sum} == op_a + op_b, modulo 2^(WIDTH+1).
  - Overflow appears only as cout; no saturation.
- Hold behaviour:
  - sum and cout hold after DONE until the next accepted start, which clears them.
  - led[4] follows cout.
- bit_a/bit_b: combinational LSBs of the shift regs; 0 outside RUN/PAUSE (regs emptied by shifting, zero after reset).
- Reset mid-operation: immediate return to IDLE with all zeros; no done pulse; partial sum discarded.
- Simultaneous start and reset: reset wins.

Test Plan:
1. Reset=1 for 10 time units with random op_a/op_b and start=0 -> all outputs 0. Release reset, hold start=0 -> state stays IDLE, led=5'b00000.
2. WIDTH=4, op_a=5, op_b=3, start pulse, runstop=0 -> done pulse exactly 5 cycles after start edge; sum=4'b1000, cout=0, led[4]=0. Bits presented LSB first: a=1,0,1,0 / b=1,1,0,0.
3. op_a=15, op_b=1 -> sum=0, cout=1, led[4]=1. carry_q=1 after each of the 4 steps.
4. op_a=6, op_b=7; runstop=1 for 3 edges after the 2nd step -> led[3]=1 during pause, busy stays 1, sum/carry frozen. Done arrives 4 cycles later than scenario 2 timing; sum=4'b1101, cout=0.
5. Start, then re-pulse start with different operands during RUN -> ignored; result matches first operands.
6. Assert reset after step 2 of op_a=9, op_b=9 -> immediate zeros and no done pulse. A new start then computes 9+9: sum=4'b0010, cout=1.

Source files
------------

// File: rtl/serial_adder_sequencer.sv
// serial_adder_sequencer
//   Walks a 1-bit full adder with a carry latch through a WIDTH-bit addition,
//   LSB first. Operands are captured on an accepted start, one bit pair is
//   consumed per run step, and each sum bit is shifted into the result
//   register from the MSB end so the result lands aligned after WIDTH steps.
//
// Ports
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset
//   start    : begin an addition (honoured only in IDLE)
//   runstop  : 1 = stop/hold, 0 = run
//   op_a/b   : operands, captured on accepted start
//   bit_a/b  : bit pair currently presented to the adder (shift reg LSBs)
//   carry_q  : carry latch
//   sum      : result register, held until the next accepted start
//   cout     : final carry of the last completed addition
//   busy     : RUN or PAUSE
//   done     : one-cycle pulse in DONE
//   led      : {cout, paused, busy, carry_q, last sum bit}
module serial_adder_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             runstop,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             bit_a,
   output logic             bit_b,
   output logic             carry_q,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done,
   output logic [4:0]       led
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_sha;
   logic [WIDTH-1:0] r_shb;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_led0;
   logic [CW-1:0]    r_cnt;

   logic w_s;
   logic w_c;
   logic w_last;

   // Full adder on the current LSB pair and the latched carry.
   assign w_s    = r_sha[0] ^ r_shb[0] ^ r_carry;
   assign w_c    = (r_sha[0] & r_shb[0]) | (r_sha[0] & r_carry) | (r_shb[0] & r_carry);
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sha   <= '0;
         r_shb   <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_led0  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sha   <= op_a;
                  r_shb   <= op_b;
                  r_carry <= 1'b0;
                  r_sum   <= '0;
                  r_cnt   <= '0;
                  r_cout  <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (runstop) begin
                  r_state <= S_PAUSE;
               end else begin
                  r_carry <= w_c;
                  r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                  r_sha   <= {1'b0, r_sha[WIDTH-1:1]};
                  r_shb   <= {1'b0, r_shb[WIDTH-1:1]};
                  r_cnt   <= r_cnt + 1'b1;
                  r_led0  <= w_s;
                  if (w_last) begin
                     r_cout  <= w_c;
                     r_state <= S_DONE;
                  end
               end
            end
            // Resuming costs one edge with no step, so each stop episode
            // adds P+1 cycles.
            S_PAUSE: begin
               if (!runstop) r_state <= S_RUN;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Shift regs are empty outside RUN/PAUSE, so these read 0 there.
   assign bit_a   = r_sha[0];
   assign bit_b   = r_shb[0];
   assign carry_q = r_carry;
   assign sum     = r_sum;
   assign cout    = r_cout;
   assign busy    = (r_state == S_RUN) || (r_state == S_PAUSE);
   assign done    = (r_state == S_DONE);
   assign led     = {r_cout, (r_state == S_PAUSE), busy, r_carry, r_led0};

endmodule
